// File: rtl/axi_msg_arbiter.sv
// Round-robin outbound push arbiter plus inbound destination router for the NoC message FIFO port.
// Outbound: 3 cycles best case from grant to req_ack, holds under FIFO backpressure; inbound: pop is combinational, then a 1-cycle gap.
module axi_msg_arbiter #(
    parameter int W_MSG = 64,
    parameter int N_REQ = 4,
    parameter int W_ID  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_rdy,
    input  logic [N_REQ*W_MSG-1:0] req_msg,
    output logic [N_REQ-1:0]       req_ack,
    output logic [N_REQ-1:0]       dst_rdy,
    output logic [W_MSG-1:0]       dst_msg,
    input  logic [N_REQ-1:0]       dst_ack,
    output logic                   f_out_rdy,
    output logic [W_MSG-1:0]       f_out_msg,
    input  logic                   f_out_ack,
    input  logic                   f_in_rdy,
    input  logic [W_MSG-1:0]       f_in_msg,
    output logic                   f_in_ack,
    output logic                   out_busy,
    output logic [7:0]             drop_cnt
);

    typedef enum logic [1:0] {OUT_IDLE, OUT_SEND, OUT_DONE} out_state_t;
    typedef enum logic {IN_IDLE, IN_GAP} in_state_t;

    out_state_t       out_state, out_nxt;
    in_state_t        in_state, in_nxt;
    logic [W_ID-1:0]  rr_ptr, gnt_q, gnt_idx, gnt_inc, dest;
    logic             gnt_any, dest_ok, drop_inc;
    logic [W_MSG-1:0] msg_q;
    int               scan;

    // Scan downward so the lowest offset from rr_ptr is assigned last and wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan = (int'(rr_ptr) + i) % N_REQ;
            if (req_rdy[scan]) begin
                gnt_any = 1'b1;
                gnt_idx = W_ID'(scan);
            end
        end
    end

    assign gnt_inc = (int'(gnt_q) == N_REQ - 1) ? '0 : gnt_q + W_ID'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_state <= OUT_IDLE;
            rr_ptr    <= '0;
            gnt_q     <= '0;
            msg_q     <= '0;
        end else begin
            out_state <= out_nxt;
            if (out_state == OUT_IDLE && gnt_any) begin
                gnt_q <= gnt_idx;
                msg_q <= req_msg[int'(gnt_idx)*W_MSG +: W_MSG];
            end
            if (out_state == OUT_SEND && f_out_ack)
                rr_ptr <= gnt_inc;
        end
    end

    always_comb begin
        out_nxt   = out_state;
        f_out_rdy = 1'b0;
        f_out_msg = '0;
        req_ack   = '0;
        case (out_state)
            OUT_IDLE: if (gnt_any) out_nxt = OUT_SEND;
            OUT_SEND: begin
                f_out_rdy = 1'b1;
                f_out_msg = msg_q;
                if (f_out_ack) out_nxt = OUT_DONE;
            end
            OUT_DONE: begin
                req_ack = N_REQ'(1) << gnt_q;
                out_nxt = OUT_IDLE;
            end
            default: out_nxt = OUT_IDLE;
        endcase
    end

    assign out_busy = (out_state != OUT_IDLE);

    assign dest    = f_in_msg[W_MSG-1 -: W_ID];
    assign dest_ok = int'(dest) < N_REQ;
    assign dst_msg = f_in_msg;

    // Unknown destinations are popped and counted so the FIFO head never wedges.
    always_comb begin
        in_nxt   = in_state;
        dst_rdy  = '0;
        f_in_ack = 1'b0;
        drop_inc = 1'b0;
        if (!rst && in_state == IN_IDLE) begin
            if (dest_ok) begin
                dst_rdy = N_REQ'(f_in_rdy) << dest;
                if (f_in_rdy && dst_ack[dest]) begin
                    f_in_ack = 1'b1;
                    in_nxt   = IN_GAP;
                end
            end else if (f_in_rdy) begin
                f_in_ack = 1'b1;
                drop_inc = 1'b1;
                in_nxt   = IN_GAP;
            end
        end else if (in_state == IN_GAP) begin
            in_nxt = IN_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_state <= IN_IDLE;
            drop_cnt <= '0;
        end else begin
            in_state <= in_nxt;
            if (drop_inc && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_axi_msg_arbiter.sv
// Directed bench for axi_msg_arbiter: a 4-requester instance for arbitration and routing, a 3-requester one for drops.
module tb_axi_msg_arbiter;
    localparam int W = 64;
    localparam int N = 4;
    localparam int N3 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]   req_rdy, req_ack, dst_rdy, dst_ack;
    logic [N*W-1:0] req_msg;
    logic [W-1:0]   dst_msg, f_out_msg, f_in_msg;
    logic           f_out_rdy, f_out_ack, f_in_rdy, f_in_ack, out_busy;
    logic [7:0]     drop_cnt;

    logic [N3-1:0]   req_rdy3, req_ack3, dst_rdy3, dst_ack3;
    logic [N3*W-1:0] req_msg3;
    logic [W-1:0]    dst_msg3, f_out_msg3, f_in_msg3;
    logic            f_out_rdy3, f_out_ack3, f_in_rdy3, f_in_ack3, out_busy3;
    logic [7:0]      drop_cnt3;

    axi_msg_arbiter #(.W_MSG(W), .N_REQ(N), .W_ID(2)) dut (
        .clk(clk), .rst(rst), .req_rdy(req_rdy), .req_msg(req_msg), .req_ack(req_ack),
        .dst_rdy(dst_rdy), .dst_msg(dst_msg), .dst_ack(dst_ack),
        .f_out_rdy(f_out_rdy), .f_out_msg(f_out_msg), .f_out_ack(f_out_ack),
        .f_in_rdy(f_in_rdy), .f_in_msg(f_in_msg), .f_in_ack(f_in_ack),
        .out_busy(out_busy), .drop_cnt(drop_cnt));

    axi_msg_arbiter #(.W_MSG(W), .N_REQ(N3), .W_ID(2)) dut3 (
        .clk(clk), .rst(rst), .req_rdy(req_rdy3), .req_msg(req_msg3), .req_ack(req_ack3),
        .dst_rdy(dst_rdy3), .dst_msg(dst_msg3), .dst_ack(dst_ack3),
        .f_out_rdy(f_out_rdy3), .f_out_msg(f_out_msg3), .f_out_ack(f_out_ack3),
        .f_in_rdy(f_in_rdy3), .f_in_msg(f_in_msg3), .f_in_ack(f_in_ack3),
        .out_busy(out_busy3), .drop_cnt(drop_cnt3));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [63:0] exp_msg;

    initial begin
        rst = 1'b1;
        req_rdy = '0; req_msg = '0; dst_ack = '0; f_out_ack = 1'b0; f_in_rdy = 1'b0; f_in_msg = '0;
        req_rdy3 = '0; req_msg3 = '0; dst_ack3 = '0; f_out_ack3 = 1'b0; f_in_rdy3 = 1'b0; f_in_msg3 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_f_out_rdy", 64'(f_out_rdy), 64'd0);
        chk("rst_req_ack", 64'(req_ack), 64'd0);
        chk("rst_out_busy", 64'(out_busy), 64'd0);
        chk("rst_dst_rdy", 64'(dst_rdy), 64'd0);
        chk("rst_f_in_ack", 64'(f_in_ack), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt3), 64'd0);
        rst = 1'b0;

        // Single request from requester 0.
        req_rdy = 4'b0001;
        req_msg[0 +: W] = 64'hA5;
        #1 chk("t1_idle_rdy", 64'(f_out_rdy), 64'd0);
        chk("t1_idle_msg", f_out_msg, 64'd0);
        @(negedge clk);
        chk("t1_send_rdy", 64'(f_out_rdy), 64'd1);
        chk("t1_send_msg", f_out_msg, 64'hA5);
        chk("t1_send_busy", 64'(out_busy), 64'd1);
        @(negedge clk);
        f_out_ack = 1'b1;
        #1 chk("t1_ack_wait", 64'(req_ack), 64'd0);
        @(negedge clk);
        f_out_ack = 1'b0;
        chk("t1_req_ack", 64'(req_ack), 64'b0001);
        chk("t1_done_rdy", 64'(f_out_rdy), 64'd0);
        chk("t1_done_msg", f_out_msg, 64'd0);
        req_rdy = 4'b0000;
        @(negedge clk);
        chk("t1_busy_clear", 64'(out_busy), 64'd0);
        chk("t1_ack_clear", 64'(req_ack), 64'd0);

        // All four requesting: grant order 0,1,2,3,0 with fresh data after each ack.
        do_reset();
        for (int k = 0; k < N; k++) req_msg[k*W +: W] = 64'h10 + 64'(k);
        req_rdy = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            #1 chk("rr_ack_width", 64'(req_ack), 64'd0);
            @(negedge clk);
            exp_msg = (n < 4) ? 64'h10 + 64'(n % 4) : 64'h20 + 64'(n % 4);
            chk("rr_grant_msg", f_out_msg, exp_msg);
            @(negedge clk);
            f_out_ack = 1'b1;
            @(negedge clk);
            f_out_ack = 1'b0;
            chk("rr_req_ack", 64'(req_ack), 64'(4'b0001 << (n % 4)));
            chk("rr_done_rdy", 64'(f_out_rdy), 64'd0);
            req_msg[(n % 4)*W +: W] = 64'h20 + 64'(n % 4);
            @(negedge clk);
        end
        req_rdy = 4'b0000;

        // FIFO full for 20 cycles with requester 2 granted.
        do_reset();
        req_rdy = 4'b0100;
        req_msg[2*W +: W] = 64'hC0DE_2222;
        @(negedge clk);
        req_msg[2*W +: W] = 64'hDEAD;
        for (int c = 0; c < 20; c++) begin
            chk("stall_rdy", 64'(f_out_rdy), 64'd1);
            chk("stall_msg", f_out_msg, 64'hC0DE_2222);
            @(negedge clk);
        end
        f_out_ack = 1'b1;
        @(negedge clk);
        f_out_ack = 1'b0;
        req_rdy = 4'b0000;
        chk("stall_req_ack", 64'(req_ack), 64'b0100);
        chk("stall_rr_ptr", 64'(dut.rr_ptr), 64'd3);
        @(negedge clk);
        chk("stall_ack_once", 64'(req_ack), 64'd0);

        // Inbound routing to requester 2, ack held 3 cycles.
        f_in_msg = 64'h8123_4567_89AB_CDEF;
        f_in_rdy = 1'b1;
        dst_ack = 4'b0001;
        #1 chk("in_dst_rdy", 64'(dst_rdy), 64'b0100);
        chk("in_dst_msg", dst_msg, 64'h8123_4567_89AB_CDEF);
        chk("in_foreign_ack", 64'(f_in_ack), 64'd0);
        @(negedge clk);
        dst_ack = 4'b0100;
        #1 chk("in_pop", 64'(f_in_ack), 64'd1);
        @(negedge clk);
        chk("in_gap_ack", 64'(f_in_ack), 64'd0);
        chk("in_gap_rdy", 64'(dst_rdy), 64'd0);
        @(negedge clk);
        f_in_rdy = 1'b0;
        #1 chk("in_empty_ack", 64'(f_in_ack), 64'd0);
        dst_ack = 4'b0000;

        // Reset mid-send with rr_ptr=3: requester 1 is granted, then discarded.
        req_rdy = 4'b0010;
        req_msg[1*W +: W] = 64'h77;
        @(negedge clk);
        chk("rs_send_msg", f_out_msg, 64'h77);
        rst = 1'b1;
        req_rdy = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        chk("rs_f_out_rdy", 64'(f_out_rdy), 64'd0);
        chk("rs_req_ack", 64'(req_ack), 64'd0);
        chk("rs_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        f_out_ack = 1'b1;
        @(negedge clk);
        f_out_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("rs_no_stale_ack", 64'(req_ack), 64'd0);
            chk("rs_idle", 64'(out_busy), 64'd0);
            @(negedge clk);
        end

        // Three-requester instance: valid dest 1, then 300 drops to dest 3.
        f_in_msg3 = 64'h4000_0000_0000_0011;
        f_in_rdy3 = 1'b1;
        #1 chk("d3_valid_rdy", 64'(dst_rdy3), 64'b010);
        chk("d3_valid_noack", 64'(f_in_ack3), 64'd0);
        f_in_msg3 = 64'hC000_0000_0000_0042;
        #1 chk("d3_drop_rdy", 64'(dst_rdy3), 64'd0);
        chk("d3_drop_ack", 64'(f_in_ack3), 64'd1);
        @(negedge clk);
        chk("d3_gap_ack", 64'(f_in_ack3), 64'd0);
        chk("d3_drop_one", 64'(drop_cnt3), 64'd1);
        for (int c = 0; c < 598; c++) @(negedge clk);
        f_in_rdy3 = 1'b0;
        chk("d3_drop_sat", 64'(drop_cnt3), 64'd255);
        @(negedge clk);
        chk("d3_drop_hold", 64'(drop_cnt3), 64'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
